// File: rtl/lut4_cell_pkg.sv
// Configuration constants and decoded configuration record shared by the
// LUT4 + enable/set/reset flip-flop cell.
package lut4_cell_pkg;

  localparam int NO_CONFIG_BITS = 19;
  localparam int INIT_LSB       = 0;
  localparam int INIT_MSB       = 15;
  localparam int FF_BIT         = 16;
  localparam int I0MUX_BIT      = 17;
  localparam int SET_BIT        = 18;
  localparam int INIT_WIDTH     = INIT_MSB - INIT_LSB + 1;

  typedef struct packed {
    logic                  set_noreset;
    logic                  i0mux;
    logic                  ff;
    logic [INIT_WIDTH-1:0] init;
  } cfg_t;

  function automatic cfg_t decode_cfg(input logic [NO_CONFIG_BITS-1:0] bits);
    cfg_t c;
    c.init        = bits[INIT_MSB:INIT_LSB];
    c.ff          = bits[FF_BIT];
    c.i0mux       = bits[I0MUX_BIT];
    c.set_noreset = bits[SET_BIT];
    return c;
  endfunction

endpackage

// File: rtl/lut4_dffesr_cell_if.sv
// Switch-matrix side pins of one LUT4 cell; master drives the cell inputs,
// slave is the cell itself.
interface lut4_dffesr_cell_if;

  logic I0;
  logic I1;
  logic I2;
  logic I3;
  logic Ci;
  logic EN;
  logic SR;
  logic O;
  logic Co;

  modport master (output I0, I1, I2, I3, Ci, EN, SR, input O, Co);
  modport slave  (input I0, I1, I2, I3, Ci, EN, SR, output O, Co);

endinterface

// File: rtl/lut4_cell_ff.sv
// Cell storage flop: async active-low reset, synchronous SR with selectable
// set/clear value (SR beats EN), clock enable.
module lut4_cell_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic sr_i,
  input  logic set_val_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // NOTE: every path assigns q_d, starting from a hold default, so no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (sr_i)      q_d = set_val_i;
    else if (en_i) q_d = d_i;
  end

  // NOTE: state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/lut4_cell_mux2.sv
// Team 2:1 mux cell; the LUT read tree is built from these.
module lut4_cell_mux2 (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);

  assign y_o = s_i ? b_i : a_i;

endmodule

// File: rtl/lut4_dffesr_cell.sv
// LUT4 with optional registered output (enable + sync set/reset) and carry.
// Define LUT4_CELL_CARRY_EN to enable the Ci->I0 mux and majority carry out.
module lut4_dffesr_cell
  import lut4_cell_pkg::*;
#(
  parameter int NoConfigBits = NO_CONFIG_BITS
) (
  input  logic                    UserCLK,
  input  logic                    resetn,
  input  logic                    I0,
  input  logic                    I1,
  input  logic                    I2,
  input  logic                    I3,
  input  logic                    Ci,
  input  logic                    EN,
  input  logic                    SR,
  output logic                    O,
  output logic                    Co,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  cfg_t cfg;
  logic i0x;
  logic l;
  logic q;

  assign cfg = decode_cfg(ConfigBits[NO_CONFIG_BITS-1:0]);

`ifdef LUT4_CELL_CARRY_EN
  assign i0x = cfg.i0mux ? Ci : I0;
  assign Co  = (Ci & I1) | (Ci & I2) | (I1 & I2);
`else
  logic unused_carry;
  assign i0x          = I0;
  assign Co           = 1'b0;
  assign unused_carry = &{1'b0, Ci, cfg.i0mux};
`endif

  // Four-level mux2 tree: level k is steered by address bit k (I0x first).
  logic [7:0] lvl1;
  logic [3:0] lvl2;
  logic [1:0] lvl3;

  for (genvar k = 0; k < 8; k++) begin : g_lvl1
    lut4_cell_mux2 u_mux (.a_i(cfg.init[2*k]), .b_i(cfg.init[2*k+1]), .s_i(i0x), .y_o(lvl1[k]));
  end
  for (genvar k = 0; k < 4; k++) begin : g_lvl2
    lut4_cell_mux2 u_mux (.a_i(lvl1[2*k]), .b_i(lvl1[2*k+1]), .s_i(I1), .y_o(lvl2[k]));
  end
  for (genvar k = 0; k < 2; k++) begin : g_lvl3
    lut4_cell_mux2 u_mux (.a_i(lvl2[2*k]), .b_i(lvl2[2*k+1]), .s_i(I2), .y_o(lvl3[k]));
  end
  lut4_cell_mux2 u_mux_top (.a_i(lvl3[0]), .b_i(lvl3[1]), .s_i(I3), .y_o(l));

  lut4_cell_ff u_ff (
    .clk       (UserCLK),
    .rst_n     (resetn),
    .sr_i      (SR),
    .set_val_i (cfg.set_noreset),
    .en_i      (EN),
    .d_i       (l),
    .q_o       (q)
  );

  assign O = cfg.ff ? q : l;

endmodule

// File: doc/lut4_dffesr_cell.md
LUT4_DFFESR_CELL -- requirements
Module: lut4_dffesr_cell

Interface
REQ-001 SHALL expose parameter NoConfigBits, default 19, giving the width of the configuration bus.
REQ-002 SHALL have port UserCLK, input, 1 bit: the single user clock; all state updates occur on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports I0, I1, I2, I3, input, 1 bit each: LUT address inputs from the switch matrix.
REQ-005 SHALL have port Ci, input, 1 bit: carry in from the neighbouring cell.
REQ-006 SHALL have port EN, input, 1 bit: register clock enable, active high.
REQ-007 SHALL have port SR, input, 1 bit: synchronous set/reset request, active high.
REQ-008 SHALL have port O, output, 1 bit: cell output, which feeds one MUX8LUT data input (A..H).
REQ-009 SHALL have port Co, output, 1 bit: carry out to the neighbouring cell.
REQ-010 SHALL have port ConfigBits, input, NoConfigBits bits: a GLOBAL-tagged static configuration bus, declared after all switch-matrix pins.
REQ-011 ConfigBits SHALL be mapped as follows: [15:0] INIT; [16] FF, where 1 selects registered output; [17] I0MUX, where 1 selects Ci as the LUT bit-0 input; [18] SET_NORESET, where 1 makes SR set and 0 makes SR clear.

Function
REQ-012 LUT output L SHALL equal INIT[{I3,I2,I1,I0x}], where I0x = I0MUX ? Ci : I0; L is purely combinational.
REQ-013 Carry out SHALL be the majority function: Co = (Ci&I1)|(Ci&I2)|(I1&I2), combinational with zero latency.
REQ-014 Register Q SHALL take one of three actions at each UserCLK rising edge while resetn=1:
- if SR=1, Q <= SET_NORESET;
- else if EN=1, Q <= L;
- else Q holds its value.
REQ-015 SR SHALL take priority over EN; SR acts regardless of the EN value.
REQ-016 O SHALL equal Q when FF=1 and L when FF=0; O carries no added latency beyond Q's single cycle.
REQ-017 The L-to-Q path SHALL have latency exactly 1 cycle: the value of L sampled at edge n appears on O after edge n.
REQ-018 ConfigBits SHALL be treated as static; a change to SET_NORESET while SR is held takes effect at the next edge only.
REQ-019 The cell SHALL contain no other state beyond Q.

Reset
REQ-020 resetn=0 SHALL force Q=0 immediately, without waiting for a clock edge, and hold Q there while low; it overrides SR and EN.
REQ-021 During reset, O SHALL be 0 when FF=1 and SHALL follow L when FF=0; Co SHALL remain combinational.
REQ-022 Q SHALL reload only at the first rising edge after resetn deasserts.
REQ-023 Reset asserted mid-operation SHALL discard Q with no residual state.

Configuration
REQ-024 Macro LUT4_CELL_CARRY_EN defined: the I0MUX selection and Co logic SHALL be present as described in REQ-012 and REQ-013.
REQ-025 Macro LUT4_CELL_CARRY_EN undefined:
- I0x SHALL be I0;
- ConfigBits[17] SHALL be ignored;
- Co SHALL be driven constant 0;
- Ci SHALL be unused;
- NoConfigBits and the bit map SHALL remain unchanged.

Structure
REQ-026 Shared package lut4_cell_pkg SHALL hold the configuration constants: NO_CONFIG_BITS=19, INIT_LSB=0, INIT_MSB=15, FF_BIT=16, I0MUX_BIT=17, SET_BIT=18.
REQ-027 The register SHALL be the sub-module lut4_cell_ff (async active-low reset, sync SR with selectable value, enable).
REQ-028 The LUT read SHALL use a 16:1 selection built from the team mux2 cell tree (4 levels), matching the other LUT-area cells.

Verification
REQ-029 INIT=16'h8000, FF=0; drive I3..I0=1111 -> O=1 same cycle; drive 1110 -> O=0.
REQ-030 INIT=16'h6996, FF=1, EN=1; apply I=0001 at edge 1 -> O=0 before edge 1, O=1 after edge 1; set EN=0 and change I -> O stays 1.
REQ-031 FF=1, SET_NORESET=1; SR=1 and EN=1 with L=0 -> O=1 after the edge; repeat with SET_NORESET=0 -> O=0 after the edge.
REQ-032 FF=1, Q=1; pull resetn low between edges -> O=0 with no clock edge; raise resetn, EN=1, L=1 -> O=1 after the next edge.
REQ-033 With LUT4_CELL_CARRY_EN defined: I0MUX=1, INIT=16'hAAAA, Ci=1, I1=1, I2=0 -> L=1, Co=1; Ci=0 -> L=0, Co=0.
REQ-034 With LUT4_CELL_CARRY_EN undefined: same stimulus as REQ-033 -> L follows I0 and Co=0 throughout.
